// File: rtl/trace_capture_buffer.sv
// rtl/trace_capture_buffer.sv - circular (pc, instr) trace buffer with PC-match trigger and frozen readout
// Optional TRACE_TIMESTAMP_EN adds a 16-bit per-entry cycle timestamp and the o_rd_ts port.
module trace_capture_buffer #(
   parameter int PC_W      = 32,
   parameter int INSTR_W   = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4,
   parameter int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_arm,
   input  logic               i_cap_valid,
   input  logic [PC_W-1:0]    i_cap_pc,
   input  logic [INSTR_W-1:0] i_cap_instr,
   input  logic [PC_W-1:0]    i_trig_pc,
   input  logic               i_rd_en,
   output logic [PC_W-1:0]    o_rd_pc,
   output logic [INSTR_W-1:0] o_rd_instr,
`ifdef TRACE_TIMESTAMP_EN
   output logic [15:0]        o_rd_ts,
`endif
   output logic               o_rd_valid,
   output logic               o_rd_empty,
   output logic               o_triggered,
   output logic               o_done,
   output logic [CNT_W-1:0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_POST,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic [CNT_W-1:0]     r_post_cnt;
   logic                 r_triggered;
   logic                 r_done;
   logic                 r_rd_valid;
   logic [PC_W-1:0]      r_rd_pc;
   logic [INSTR_W-1:0]   r_rd_instr;

   logic [PC_W-1:0]      r_mem_pc    [DEPTH];
   logic [INSTR_W-1:0]   r_mem_instr [DEPTH];

   logic                 w_write;
   logic                 w_full;
   logic                 w_hit;

   assign w_write = i_cap_valid && ((r_state == S_ARMED) || (r_state == S_POST));
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_hit   = (i_cap_pc == i_trig_pc);

`ifdef TRACE_TIMESTAMP_EN
   logic [15:0] r_ts;
   logic [15:0] r_mem_ts [DEPTH];
   logic [15:0] r_rd_ts;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_ts    <= 16'd0;
         r_rd_ts <= 16'd0;
      end else begin
         r_ts <= r_ts + 16'd1;
         if ((r_state == S_DONE) && i_rd_en && !i_arm && (r_count != '0))
            r_rd_ts <= r_mem_ts[r_rd_ptr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_write)
         r_mem_ts[r_wr_ptr] <= r_ts;
   end

   assign o_rd_ts = r_rd_ts;
`endif

   // Trace RAM is deliberately not reset; only the pointers define its contents.
   always_ff @(posedge i_clk) begin
      if (w_write) begin
         r_mem_pc[r_wr_ptr]    <= i_cap_pc;
         r_mem_instr[r_wr_ptr] <= i_cap_instr;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_post_cnt  <= '0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_pc     <= '0;
         r_rd_instr  <= '0;
      end else begin
         r_rd_valid <= 1'b0;

         // Once full, every write overwrites the oldest entry, so the read pointer follows.
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_full)
               r_rd_ptr <= r_rd_ptr + AW'(1);
            else
               r_count <= r_count + CNT_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (i_arm) begin
                  r_wr_ptr    <= '0;
                  r_rd_ptr    <= '0;
                  r_count     <= '0;
                  r_post_cnt  <= '0;
                  r_triggered <= 1'b0;
                  r_state     <= S_ARMED;
               end
            end

            S_ARMED: begin
               if (i_cap_valid && w_hit) begin
                  r_triggered <= 1'b1;
                  r_post_cnt  <= CNT_W'(POST_TRIG);
                  if (POST_TRIG == 0) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_POST;
                  end
               end
            end

            S_POST: begin
               if (i_cap_valid) begin
                  r_post_cnt <= r_post_cnt - CNT_W'(1);
                  if (r_post_cnt == CNT_W'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               // A re-arm discards the unread window and takes priority over a same-cycle pop.
               if (i_arm) begin
                  r_wr_ptr    <= '0;
                  r_rd_ptr    <= '0;
                  r_count     <= '0;
                  r_post_cnt  <= '0;
                  r_triggered <= 1'b0;
                  r_done      <= 1'b0;
                  r_state     <= S_ARMED;
               end else if (i_rd_en && (r_count != '0)) begin
                  r_rd_pc    <= r_mem_pc[r_rd_ptr];
                  r_rd_instr <= r_mem_instr[r_rd_ptr];
                  r_rd_valid <= 1'b1;
                  r_rd_ptr   <= r_rd_ptr + AW'(1);
                  r_count    <= r_count - CNT_W'(1);
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_rd_pc     = r_rd_pc;
   assign o_rd_instr  = r_rd_instr;
   assign o_rd_valid  = r_rd_valid;
   assign o_rd_empty  = (r_count == '0);
   assign o_triggered = r_triggered;
   assign o_done      = r_done;
   assign o_count     = r_count;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb/tb_trace_capture_buffer.sv - directed self-checking bench for trace_capture_buffer
module tb_trace_capture_buffer;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 5;

   logic               i_clk = 1'b0;
   logic               i_reset;
   logic               i_arm;
   logic               i_cap_valid;
   logic [PC_W-1:0]    i_cap_pc;
   logic [INSTR_W-1:0] i_cap_instr;
   logic [PC_W-1:0]    i_trig_pc;
   logic               i_rd_en;
   logic [PC_W-1:0]    o_rd_pc;
   logic [INSTR_W-1:0] o_rd_instr;
`ifdef TRACE_TIMESTAMP_EN
   logic [15:0]        o_rd_ts;
`endif
   logic               o_rd_valid;
   logic               o_rd_empty;
   logic               o_triggered;
   logic               o_done;
   logic [CNT_W-1:0]   o_count;

   int n_pass  = 0;
   int n_total = 0;

   always #5 i_clk = ~i_clk;

   trace_capture_buffer #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(16), .POST_TRIG(4)
   ) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_arm(i_arm),
      .i_cap_valid(i_cap_valid),
      .i_cap_pc(i_cap_pc),
      .i_cap_instr(i_cap_instr),
      .i_trig_pc(i_trig_pc),
      .i_rd_en(i_rd_en),
      .o_rd_pc(o_rd_pc),
      .o_rd_instr(o_rd_instr),
`ifdef TRACE_TIMESTAMP_EN
      .o_rd_ts(o_rd_ts),
`endif
      .o_rd_valid(o_rd_valid),
      .o_rd_empty(o_rd_empty),
      .o_triggered(o_triggered),
      .o_done(o_done),
      .o_count(o_count)
   );

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return pc ^ 32'h5A5A_0000;
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_arm(input logic [31:0] trig);
      i_trig_pc = trig;
      i_arm = 1'b1;
      step();
      i_arm = 1'b0;
   endtask

   task automatic feed(input logic [31:0] pc, input int gap);
      i_cap_valid = 1'b1;
      i_cap_pc    = pc;
      i_cap_instr = mk_instr(pc);
      step();
      i_cap_valid = 1'b0;
      i_cap_pc    = pc + 32'd1;
      repeat (gap) step();
   endtask

   task automatic feed_until_done(input int gap, output int last_k);
      last_k = -1;
      for (int k = 0; k < 64 && !o_done; k++) begin
         feed(32'(4 * k), gap);
         last_k = k;
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b0; i_arm = 1'b0; i_cap_valid = 1'b0; i_cap_pc = '0;
      i_cap_instr = '0; i_trig_pc = '0; i_rd_en = 1'b0;
      repeat (3) step();
      n_total++; if (o_count !== 5'd0) $display("FAIL rst_count: got %0d exp 0", o_count); else n_pass++;
      n_total++; if (o_rd_empty !== 1'b1) $display("FAIL rst_empty: got %0b exp 1", o_rd_empty); else n_pass++;
      n_total++; if (o_done !== 1'b0) $display("FAIL rst_done: got %0b exp 0", o_done); else n_pass++;
      n_total++; if (o_triggered !== 1'b0) $display("FAIL rst_trig: got %0b exp 0", o_triggered); else n_pass++;
      n_total++; if (o_rd_valid !== 1'b0 || o_rd_pc !== 32'd0) $display("FAIL rst_rd: got valid=%0b pc=%0h exp 0/0", o_rd_valid, o_rd_pc); else n_pass++;
      i_reset = 1'b1;
      step();
      i_rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++; if (o_rd_valid !== 1'b0) $display("FAIL idle_rd_valid[%0d]: got %0b exp 0", i, o_rd_valid); else n_pass++;
      end
      i_rd_en = 1'b0;
      do_arm(32'hFFFF_0000);
      for (int k = 0; k < 3; k++) feed(32'(4 * k), 0);
      n_total++; if (o_count !== 5'd3) $display("FAIL armed_count: got %0d exp 3", o_count); else n_pass++;
      i_reset = 1'b0;
      #1;
      n_total++; if (o_count !== 5'd0 || o_rd_empty !== 1'b1) $display("FAIL async_rst: got count=%0d empty=%0b exp 0/1", o_count, o_rd_empty); else n_pass++;
      step();
      i_reset = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int last_k;
      do_arm(32'd40);
      feed_until_done(0, last_k);
      n_total++; if (o_done !== 1'b1 || last_k != 14) $display("FAIL basic_done: got done=%0b last_pc=%0d exp 1/56", o_done, 4 * last_k); else n_pass++;
      n_total++; if (o_count !== 5'd15) $display("FAIL basic_count: got %0d exp 15", o_count); else n_pass++;
      n_total++; if (o_triggered !== 1'b1) $display("FAIL basic_trig: got %0b exp 1", o_triggered); else n_pass++;
      i_rd_en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         n_total++;
         if (o_rd_valid !== 1'b1 || o_rd_pc !== 32'(4 * i) || o_rd_instr !== mk_instr(32'(4 * i)))
            $display("FAIL basic_rd[%0d]: got v=%0b pc=%0d instr=%0h exp 1/%0d/%0h", i, o_rd_valid, o_rd_pc, o_rd_instr, 4 * i, mk_instr(32'(4 * i)));
         else n_pass++;
      end
      n_total++; if (o_rd_empty !== 1'b1 || o_count !== 5'd0) $display("FAIL basic_empty: got empty=%0b count=%0d exp 1/0", o_rd_empty, o_count); else n_pass++;
      step();
      n_total++; if (o_rd_valid !== 1'b0) $display("FAIL basic_empty_rd: got %0b exp 0", o_rd_valid); else n_pass++;
      i_rd_en = 1'b0;
   endtask

   task automatic test_wrap();
      int last_k;
      do_arm(32'd100);
      n_total++; if (o_done !== 1'b0 || o_triggered !== 1'b0 || o_count !== 5'd0) $display("FAIL rearm: got done=%0b trig=%0b count=%0d exp 0/0/0", o_done, o_triggered, o_count); else n_pass++;
      feed_until_done(0, last_k);
      n_total++; if (o_done !== 1'b1 || last_k != 29) $display("FAIL wrap_done: got done=%0b last_pc=%0d exp 1/116", o_done, 4 * last_k); else n_pass++;
      n_total++; if (o_count !== 5'd16) $display("FAIL wrap_count: got %0d exp 16", o_count); else n_pass++;
      i_rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         n_total++;
         if (o_rd_valid !== 1'b1 || o_rd_pc !== 32'(56 + 4 * i))
            $display("FAIL wrap_rd[%0d]: got v=%0b pc=%0d exp 1/%0d", i, o_rd_valid, o_rd_pc, 56 + 4 * i);
         else n_pass++;
      end
      i_rd_en = 1'b0;
      n_total++; if (o_rd_empty !== 1'b1) $display("FAIL wrap_empty: got %0b exp 1", o_rd_empty); else n_pass++;
   endtask

   task automatic test_stall();
      do_arm(32'd40);
      for (int k = 0; k <= 12; k++) feed(32'(4 * k), 0);
      n_total++; if (o_count !== 5'd13 || o_done !== 1'b0 || o_triggered !== 1'b1) $display("FAIL stall_pre: got count=%0d done=%0b trig=%0b exp 13/0/1", o_count, o_done, o_triggered); else n_pass++;
      for (int s = 0; s < 3; s++) begin
         i_cap_valid = 1'b0;
         i_cap_pc = 32'd40 + 32'(s);
         i_arm = (s == 1);
         step();
      end
      i_arm = 1'b0;
      n_total++; if (o_count !== 5'd13 || o_done !== 1'b0 || o_triggered !== 1'b1) $display("FAIL stall_hold: got count=%0d done=%0b trig=%0b exp 13/0/1", o_count, o_done, o_triggered); else n_pass++;
      feed(32'd52, 0);
      n_total++; if (o_done !== 1'b0) $display("FAIL stall_resume: got done=%0b exp 0", o_done); else n_pass++;
      feed(32'd56, 0);
      n_total++; if (o_done !== 1'b1 || o_count !== 5'd15) $display("FAIL stall_done: got done=%0b count=%0d exp 1/15", o_done, o_count); else n_pass++;
      i_rd_en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         n_total++;
         if (o_rd_valid !== 1'b1 || o_rd_pc !== 32'(4 * i))
            $display("FAIL stall_rd[%0d]: got v=%0b pc=%0d exp 1/%0d", i, o_rd_valid, o_rd_pc, 4 * i);
         else n_pass++;
      end
      i_rd_en = 1'b0;
   endtask

   task automatic test_reset_post();
      int last_k;
      do_arm(32'd40);
      for (int k = 0; k <= 12; k++) feed(32'(4 * k), 0);
      i_reset = 1'b0;
      #1;
      n_total++; if (o_count !== 5'd0 || o_done !== 1'b0 || o_triggered !== 1'b0 || o_rd_empty !== 1'b1) $display("FAIL post_rst: got count=%0d done=%0b trig=%0b empty=%0b exp 0/0/0/1", o_count, o_done, o_triggered, o_rd_empty); else n_pass++;
      step();
      i_reset = 1'b1;
      step();
      do_arm(32'd40);
      feed_until_done(0, last_k);
      n_total++; if (o_done !== 1'b1 || last_k != 14 || o_count !== 5'd15) $display("FAIL post_rerun: got done=%0b last_pc=%0d count=%0d exp 1/56/15", o_done, 4 * last_k, o_count); else n_pass++;
      i_rd_en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         n_total++;
         if (o_rd_valid !== 1'b1 || o_rd_pc !== 32'(4 * i))
            $display("FAIL post_rd[%0d]: got v=%0b pc=%0d exp 1/%0d", i, o_rd_valid, o_rd_pc, 4 * i);
         else n_pass++;
      end
      i_rd_en = 1'b0;
   endtask

   task automatic test_arm_vs_read();
      int last_k;
      do_arm(32'd8);
      feed_until_done(0, last_k);
      n_total++; if (o_done !== 1'b1 || o_count !== 5'd7) $display("FAIL avr_pre: got done=%0b count=%0d exp 1/7", o_done, o_count); else n_pass++;
      i_arm = 1'b1;
      i_rd_en = 1'b1;
      step();
      i_arm = 1'b0;
      i_rd_en = 1'b0;
      n_total++; if (o_rd_valid !== 1'b0 || o_done !== 1'b0 || o_count !== 5'd0 || o_triggered !== 1'b0) $display("FAIL avr: got v=%0b done=%0b count=%0d trig=%0b exp 0/0/0/0", o_rd_valid, o_done, o_count, o_triggered); else n_pass++;
      feed_until_done(0, last_k);
      n_total++; if (o_done !== 1'b1 || o_count !== 5'd7) $display("FAIL avr_again: got done=%0b count=%0d exp 1/7", o_done, o_count); else n_pass++;
   endtask

`ifdef TRACE_TIMESTAMP_EN
   task automatic test_timestamp();
      int last_k;
      logic [15:0] prev;
      do_arm(32'd40);
      feed_until_done(1, last_k);
      n_total++; if (o_count !== 5'd15) $display("FAIL ts_count: got %0d exp 15", o_count); else n_pass++;
      i_rd_en = 1'b1;
      prev = '0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (i > 0) begin
            n_total++;
            if (o_rd_valid !== 1'b1 || (o_rd_ts - prev) !== 16'd2)
               $display("FAIL ts_delta[%0d]: got v=%0b delta=%0d exp 1/2", i, o_rd_valid, o_rd_ts - prev);
            else n_pass++;
         end
         prev = o_rd_ts;
      end
      i_rd_en = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_reset_post();
      test_arm_vs_read();
`ifdef TRACE_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
